motion_track_ctrl: RTL and testbench

- Frame-level controller for the frame-difference motion path. Counts motion pixels in the binary difference mask each frame.
- Applies warm-up, trigger debounce and hold-off hysteresis. Decides whether the rectangle overlay is shown and which bounding box it uses.
- Sits between the per-frame box tracker (running extents) and the overlay/marking stage. Drives overlay enable, latched box coordinates and a motion alarm.

---
 rtl/motion_track_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_motion_track_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_track_ctrl.sv
// motion_track_ctrl: frame-level controller for the frame-difference motion path.
// Counts motion pixels per frame, applies warm-up, trigger debounce and hold-off
// hysteresis, and decides whether the overlay rectangle is shown and with which box.
module motion_track_ctrl #(
    parameter int WARMUP_FRAMES = 4,
    parameter int TRIG_FRAMES   = 2,
    parameter int HOLD_FRAMES   = 15,
    parameter int PIX_THRESH    = 200,
    parameter int CNT_W         = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             per_frame_vsync,
    input  logic             per_frame_href,
    input  logic             per_frame_clken,
    input  logic             per_img_Y,
    input  logic [9:0]       box_up,
    input  logic [9:0]       box_down,
    input  logic [9:0]       box_left,
    input  logic [9:0]       box_right,
    output logic [9:0]       edg_up_o,
    output logic [9:0]       edg_down_o,
    output logic [9:0]       edg_left_o,
    output logic [9:0]       edg_right_o,
    output logic             overlay_en,
    output logic             motion_alarm,
    output logic [2:0]       ctrl_state,
    output logic [CNT_W-1:0] pix_cnt_last,
    output logic [15:0]      frame_cnt
);

    typedef enum logic [2:0] {
        ST_WARMUP = 3'd0,
        ST_IDLE   = 3'd1,
        ST_ARMING = 3'd2,
        ST_TRACK  = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    localparam logic [15:0]      WARM_LAST = 16'(WARMUP_FRAMES - 1);
    localparam logic [15:0]      TRIG_N    = 16'(TRIG_FRAMES);
    localparam logic [15:0]      HOLD_N    = 16'(HOLD_FRAMES);
    localparam logic [CNT_W-1:0] THRESH    = CNT_W'(PIX_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next_state;
    logic             r_vsync;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [15:0]      r_warm_cnt;
    logic [15:0]      r_trig_cnt;
    logic [15:0]      r_hold_cnt;
    logic [15:0]      w_warm_nxt;
    logic [15:0]      w_trig_nxt;
    logic [15:0]      w_hold_nxt;
    logic             w_alarm_nxt;
    logic             w_vs_rise;
    logic             w_fe;
    logic             w_pix_in;
    logic             w_hit;

    assign w_vs_rise  = per_frame_vsync & ~r_vsync;
    assign w_fe       = r_vsync & ~per_frame_vsync;
    assign w_pix_in   = per_frame_href & per_frame_clken & per_img_Y;
    // An inverted box means the tracker saw nothing, so it is a miss whatever the count.
    assign w_hit      = (r_pix_cnt >= THRESH) && (box_down >= box_up) && (box_right >= box_left);
    assign ctrl_state = r_state;

    // vsync delay register for frame start / frame end edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vsync <= 1'b0;
        end else begin
            r_vsync <= per_frame_vsync;
        end
    end

    // Motion pixel counter: cleared at frame start (that cycle's pixel included), saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= {CNT_W{1'b0}};
        end else if (w_vs_rise) begin
            r_pix_cnt <= w_pix_in ? CNT_ONE : {CNT_W{1'b0}};
        end else if (per_frame_vsync && w_pix_in && (r_pix_cnt != CNT_MAX)) begin
            r_pix_cnt <= r_pix_cnt + CNT_ONE;
        end else begin
            r_pix_cnt <= r_pix_cnt;
        end
    end

    // Next-state and counter updates; the FSM only moves on frame-end cycles
    always_comb begin
        w_next_state = r_state;
        w_warm_nxt   = r_warm_cnt;
        w_trig_nxt   = r_trig_cnt;
        w_hold_nxt   = r_hold_cnt;
        w_alarm_nxt  = 1'b0;
        case (r_state)
            ST_WARMUP: begin
                if (w_fe) begin
                    w_warm_nxt = r_warm_cnt + 16'd1;
                    if (r_warm_cnt == WARM_LAST) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_WARMUP;
                    end
                end else begin
                    w_warm_nxt = r_warm_cnt;
                end
            end
            ST_IDLE: begin
                if (w_fe && w_hit) begin
                    if (TRIG_N == 16'd1) begin
                        w_next_state = ST_TRACK;
                        w_alarm_nxt  = 1'b1;
                    end else begin
                        w_next_state = ST_ARMING;
                        w_trig_nxt   = 16'd1;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ARMING: begin
                if (w_fe) begin
                    if (w_hit) begin
                        w_trig_nxt = r_trig_cnt + 16'd1;
                        if ((r_trig_cnt + 16'd1) == TRIG_N) begin
                            w_next_state = ST_TRACK;
                            w_alarm_nxt  = 1'b1;
                        end else begin
                            w_next_state = ST_ARMING;
                        end
                    end else begin
                        w_next_state = ST_IDLE;
                        w_trig_nxt   = 16'd0;
                    end
                end else begin
                    w_next_state = ST_ARMING;
                end
            end
            ST_TRACK: begin
                if (w_fe && !w_hit) begin
                    w_hold_nxt = 16'd0;
                    if (HOLD_N == 16'd0) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_HOLD;
                    end
                end else begin
                    w_next_state = ST_TRACK;
                end
            end
            ST_HOLD: begin
                if (w_fe) begin
                    if (w_hit) begin
                        w_next_state = ST_TRACK;
                        w_hold_nxt   = 16'd0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + 16'd1;
                        if ((r_hold_cnt + 16'd1) == HOLD_N) begin
                            w_next_state = ST_IDLE;
                        end else begin
                            w_next_state = ST_HOLD;
                        end
                    end
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State and hysteresis counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_WARMUP;
            r_warm_cnt <= 16'd0;
            r_trig_cnt <= 16'd0;
            r_hold_cnt <= 16'd0;
        end else begin
            r_state    <= w_next_state;
            r_warm_cnt <= w_warm_nxt;
            r_trig_cnt <= w_trig_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    // Overlay enable and new-event alarm, updated together with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overlay_en   <= 1'b0;
            motion_alarm <= 1'b0;
        end else begin
            overlay_en   <= (w_next_state == ST_TRACK) || (w_next_state == ST_HOLD);
            motion_alarm <= w_alarm_nxt;
        end
    end

    // Box latch: capture the tracker extents only on frame ends that land in TRACK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edg_up_o    <= 10'd0;
            edg_down_o  <= 10'd0;
            edg_left_o  <= 10'd0;
            edg_right_o <= 10'd0;
        end else if (w_fe && (w_next_state == ST_TRACK)) begin
            edg_up_o    <= box_up;
            edg_down_o  <= box_down;
            edg_left_o  <= box_left;
            edg_right_o <= box_right;
        end else begin
            edg_up_o    <= edg_up_o;
            edg_down_o  <= edg_down_o;
            edg_left_o  <= edg_left_o;
            edg_right_o <= edg_right_o;
        end
    end

    // Per-frame statistics captured at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_last <= {CNT_W{1'b0}};
            frame_cnt    <= 16'd0;
        end else if (w_fe) begin
            pix_cnt_last <= r_pix_cnt;
            frame_cnt    <= frame_cnt + 16'd1;
        end else begin
            pix_cnt_last <= pix_cnt_last;
            frame_cnt    <= frame_cnt;
        end
    end

endmodule

// File: tb/tb_motion_track_ctrl.sv
// Self-checking bench for motion_track_ctrl: a frame-level reference model pushes the
// expected outputs into a queue as each frame is driven; they are popped and compared
// once the frame-end edge has been taken by the DUT.
module tb_motion_track_ctrl;

    logic        clk;
    logic        rst_n;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic        per_img_Y;
    logic [9:0]  box_up, box_down, box_left, box_right;
    logic [9:0]  edg_up_o, edg_down_o, edg_left_o, edg_right_o;
    logic        overlay_en;
    logic        motion_alarm;
    logic [2:0]  ctrl_state;
    logic [18:0] pix_cnt_last;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0]  st;
        logic        ov;
        logic        al;
        logic [39:0] box;
        logic [18:0] pix;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];

    // reference model state
    int          m_state, m_warm, m_trig, m_hold;
    logic [39:0] m_box;
    logic [15:0] m_frame;

    motion_track_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .per_img_Y       (per_img_Y),
        .box_up          (box_up),
        .box_down        (box_down),
        .box_left        (box_left),
        .box_right       (box_right),
        .edg_up_o        (edg_up_o),
        .edg_down_o      (edg_down_o),
        .edg_left_o      (edg_left_o),
        .edg_right_o     (edg_right_o),
        .overlay_en      (overlay_en),
        .motion_alarm    (motion_alarm),
        .ctrl_state      (ctrl_state),
        .pix_cnt_last    (pix_cnt_last),
        .frame_cnt       (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_warm = 0; m_trig = 0; m_hold = 0;
        m_box = 40'd0; m_frame = 16'd0;
    endtask

    // Frame-level reference: WARMUP 4, TRIG 2, HOLD 15, threshold 200
    task automatic model_frame(input int cnt, input int u, input int d, input int l, input int r);
        bit   hit;
        int   nxt;
        exp_t e;
        hit = (cnt >= 200) && (d >= u) && (r >= l);
        nxt = m_state;
        e.al = 1'b0;
        case (m_state)
            0: begin if (m_warm == 3) nxt = 1; m_warm++; end
            1: begin if (hit) begin nxt = 2; m_trig = 1; end end
            2: begin
                if (hit) begin
                    m_trig++;
                    if (m_trig == 2) begin nxt = 3; e.al = 1'b1; end
                end else begin
                    nxt = 1; m_trig = 0;
                end
            end
            3: begin if (!hit) begin nxt = 4; m_hold = 0; end end
            4: begin
                if (hit) begin nxt = 3; m_hold = 0; end
                else begin m_hold++; if (m_hold == 15) nxt = 1; end
            end
            default: nxt = 1;
        endcase
        if (nxt == 3) m_box = {10'(u), 10'(d), 10'(l), 10'(r)};
        m_frame = m_frame + 16'd1;
        m_state = nxt;
        e.st  = 3'(nxt);
        e.ov  = (nxt == 3) || (nxt == 4);
        e.box = m_box;
        e.pix = 19'(cnt);
        e.fc  = m_frame;
        exp_q.push_back(e);
    endtask

    // Drive one frame of npix mask pixels (cont=1: vsync already high) and check its outputs
    task automatic drive_frame(input string tag, input int npix, input int u, input int d,
                               input int l, input int r, input bit cont);
        exp_t e;
        model_frame(npix, u, d, l, r);
        if (!cont) begin
            // a pixel while vsync is low must not be counted
            @(negedge clk);
            per_frame_vsync = 1'b0; per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_Y = 1'b1;
            @(negedge clk);
            per_frame_vsync = 1'b1; per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Y = 1'b0;
            repeat (2) @(negedge clk);
        end
        for (int i = 0; i < npix; i++) begin
            @(negedge clk);
            per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_Y = 1'b1;
            if (i % 8 == 3) begin
                @(negedge clk);
                per_frame_clken = 1'b0;
                @(negedge clk);
                per_frame_clken = 1'b1; per_img_Y = 1'b0;
            end
        end
        @(negedge clk);
        per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Y = 1'b0;
        @(negedge clk);
        per_frame_vsync = 1'b0;
        box_up = 10'(u); box_down = 10'(d); box_left = 10'(l); box_right = 10'(r);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (ctrl_state !== e.st) begin
            bad++; $display("FAIL %s state: got %0d want %0d", tag, ctrl_state, e.st);
        end
        total++;
        if (overlay_en !== e.ov) begin
            bad++; $display("FAIL %s overlay_en: got %0d want %0d", tag, overlay_en, e.ov);
        end
        total++;
        if (motion_alarm !== e.al) begin
            bad++; $display("FAIL %s motion_alarm: got %0d want %0d", tag, motion_alarm, e.al);
        end
        total++;
        if ({edg_up_o, edg_down_o, edg_left_o, edg_right_o} !== e.box) begin
            bad++; $display("FAIL %s box: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", tag,
                            edg_up_o, edg_down_o, edg_left_o, edg_right_o,
                            e.box[39:30], e.box[29:20], e.box[19:10], e.box[9:0]);
        end
        total++;
        if (pix_cnt_last !== e.pix) begin
            bad++; $display("FAIL %s pix_cnt_last: got %0d want %0d", tag, pix_cnt_last, e.pix);
        end
        total++;
        if (frame_cnt !== e.fc) begin
            bad++; $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, e.fc);
        end
        @(negedge clk);
        total++;
        if (motion_alarm !== 1'b0) begin
            bad++; $display("FAIL %s alarm_width: got %0d want 0", tag, motion_alarm);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Y = 1'b0;
        box_up = 10'd0; box_down = 10'd0; box_left = 10'd0; box_right = 10'd0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({ctrl_state, overlay_en, motion_alarm} !== 5'd0) begin
            bad++; $display("FAIL reset ctrl: got st=%0d ov=%0d al=%0d want 0", ctrl_state, overlay_en, motion_alarm);
        end
        total++;
        if ({edg_up_o, edg_down_o, edg_left_o, edg_right_o, pix_cnt_last, frame_cnt} !== 75'd0) begin
            bad++; $display("FAIL reset data: got pix=%0d fc=%0d want 0", pix_cnt_last, frame_cnt);
        end
    endtask

    task automatic test_warmup();
        for (int f = 0; f < 4; f++) drive_frame("warmup", 500, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_trigger();
        drive_frame("trig1", 500, 50, 90, 60, 120, 1'b0);
        drive_frame("trig2", 500, 50, 90, 60, 120, 1'b0);
    endtask

    task automatic test_hold_return();
        for (int f = 0; f < 3; f++) drive_frame("hold_miss", 0, 0, 0, 0, 0, 1'b0);
        drive_frame("hold_hit", 300, 10, 20, 30, 40, 1'b0);
    endtask

    task automatic test_hold_expire();
        for (int f = 0; f < 16; f++) drive_frame("hold_expire", 0, 0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_arming_abort();
        drive_frame("arm_a", 500, 50, 90, 60, 120, 1'b0);
        drive_frame("arm_thr", 199, 50, 90, 60, 120, 1'b0);
        drive_frame("arm_b", 500, 50, 90, 60, 120, 1'b0);
        drive_frame("arm_inv", 500, 90, 50, 60, 120, 1'b0);
    endtask

    task automatic test_async_reset();
        drive_frame("rt1", 500, 50, 90, 60, 120, 1'b0);
        drive_frame("rt2", 500, 50, 90, 60, 120, 1'b0);
        @(negedge clk);
        per_frame_vsync = 1'b1;
        repeat (5) begin
            @(negedge clk);
            per_frame_href = 1'b1; per_frame_clken = 1'b1; per_img_Y = 1'b1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({ctrl_state, overlay_en, motion_alarm} !== 5'd0) begin
            bad++; $display("FAIL async_rst ctrl: got st=%0d ov=%0d want 0", ctrl_state, overlay_en);
        end
        total++;
        if ({edg_up_o, edg_down_o, edg_left_o, edg_right_o, pix_cnt_last, frame_cnt} !== 75'd0) begin
            bad++; $display("FAIL async_rst data: got fc=%0d up=%0d want 0", frame_cnt, edg_up_o);
        end
        model_reset();
        @(negedge clk);
        per_frame_href = 1'b0; per_frame_clken = 1'b0; per_img_Y = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // release with vsync high: the partial frame is counted and absorbed by warm-up
        drive_frame("partial", 50, 50, 90, 60, 120, 1'b1);
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_trigger();
        test_hold_return();
        test_hold_expire();
        test_arming_abort();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
